// File: rtl/srcnn_row_addr_gen.sv
// Raster-order row/column address sequencer that feeds the shared row*width multiplier.
// Optional SRCNN_ADDR_BASE_EN adds a cfg_base offset that is added into row_base.
module srcnn_row_addr_gen #(
  parameter int ROW_W  = 7,
  parameter int COL_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [COL_W-1:0]  cfg_width,
`ifdef SRCNN_ADDR_BASE_EN
  input  logic [ADDR_W-1:0] cfg_base,
`endif
  output logic [ROW_W-1:0]  mul_din0,
  output logic [COL_W-1:0]  mul_din1,
  input  logic [ADDR_W-1:0] mul_dout,
  output logic [ADDR_W-1:0] addr_data,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ROW_W-1:0]  row, rows_q;
  logic [COL_W-1:0]  col, width_q;
  logic [ADDR_W-1:0] row_base, base;
  logic              fire, col_end, row_end, cfg_zero;

  assign fire     = addr_valid & addr_ready;
  assign col_end  = col == width_q - COL_W'(1);
  assign row_end  = row == rows_q - ROW_W'(1);
  assign cfg_zero = (cfg_rows == '0) || (cfg_width == '0);

`ifdef SRCNN_ADDR_BASE_EN
  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      base_q <= '0;
    else if (state == S_IDLE && ap_start)
      base_q <= cfg_base;
  end

  assign base = base_q;
`else
  assign base = '0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (ap_start)
          state_nx = cfg_zero ? S_DONE : S_CALC;
      end
      S_CALC: state_nx = S_EMIT;
      S_EMIT: begin
        if (fire && col_end)
          state_nx = row_end ? S_DONE : S_CALC;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle    = state == S_IDLE;
    ap_done    = state == S_DONE;
    ap_ready   = state == S_DONE;
    addr_valid = state == S_EMIT;
    addr_data  = '0;
    if (addr_valid)
      addr_data = row_base + ADDR_W'(col);
    addr_last  = addr_valid & row_end & col_end;
  end

  // Multiplier operands are registered so they only move on entry to CALC.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rows_q   <= '0;
      width_q  <= '0;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      mul_din0 <= '0;
      mul_din1 <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            rows_q  <= cfg_rows;
            width_q <= cfg_width;
            row     <= '0;
            col     <= '0;
            if (!cfg_zero) begin
              mul_din0 <= '0;
              mul_din1 <= cfg_width;
            end
          end
        end
        S_CALC: row_base <= mul_dout + base;
        S_EMIT: begin
          if (fire) begin
            if (!col_end) begin
              col <= col + COL_W'(1);
            end else if (!row_end) begin
              col      <= '0;
              row      <= row + ROW_W'(1);
              mul_din0 <= row + ROW_W'(1);
              mul_din1 <= width_q;
            end
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srcnn_row_addr_gen.sv
// Randomised and directed bench for srcnn_row_addr_gen against a raster-walk model.
// Define SRCNN_ADDR_BASE_EN for both files to exercise the cfg_base offset.
module tb_srcnn_row_addr_gen;
  localparam int ROW_W  = 7;
  localparam int COL_W  = 8;
  localparam int ADDR_W = 14;
`ifdef SRCNN_ADDR_BASE_EN
  localparam bit BASE_EN = 1'b1;
`else
  localparam bit BASE_EN = 1'b0;
`endif

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              ap_start = 1'b0;
  logic              ap_done, ap_idle, ap_ready;
  logic [ROW_W-1:0]  cfg_rows = '0;
  logic [COL_W-1:0]  cfg_width = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [ROW_W-1:0]  mul_din0;
  logic [COL_W-1:0]  mul_din1;
  logic [ADDR_W-1:0] mul_dout;
  logic [ADDR_W-1:0] addr_data;
  logic              addr_valid;
  logic              addr_ready = 1'b0;
  logic              addr_last;

  int checks = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  assign mul_dout = ADDR_W'(mul_din0 * mul_din1);

  srcnn_row_addr_gen dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .cfg_rows   (cfg_rows),
    .cfg_width  (cfg_width),
`ifdef SRCNN_ADDR_BASE_EN
    .cfg_base   (cfg_base),
`endif
    .mul_din0   (mul_din0),
    .mul_din1   (mul_din1),
    .mul_dout   (mul_dout),
    .addr_data  (addr_data),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_last  (addr_last)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0
  task automatic walk(input int r, input int w, input int b, input int mode);
    int q[$];
    int e, edges, beats, budget, exp_edges, k;
    logic [ADDR_W-1:0] pdata;
    logic pvalid, pready, plast;
    for (int i = 0; i < r; i++)
      for (int j = 0; j < w; j++)
        q.push_back((b + i * w + j) % (1 << ADDR_W));
    exp_edges = (r == 0 || w == 0) ? 1 : r * (w + 1) + 1;
    budget = 10 * exp_edges + 50;
    k = 0;
    @(negedge ap_clk);
    cfg_rows  = ROW_W'(r);
    cfg_width = COL_W'(w);
    cfg_base  = ADDR_W'(b);
    ap_start  = 1'b1;
    addr_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start  = 1'b0;
    cfg_rows  = ROW_W'($urandom);
    cfg_width = COL_W'($urandom);
    cfg_base  = ADDR_W'($urandom);
    edges = 1;
    beats = 0;
    pvalid = 1'b0;
    pready = 1'b1;
    pdata = '0;
    plast = 1'b0;
    while (!ap_done && edges < budget) begin
      if (pvalid && !pready) begin
        check("stall_valid", addr_valid, 1);
        check("stall_data", addr_data, pdata);
        check("stall_last", addr_last, plast);
      end
      case (mode)
        1: addr_ready = 1'($urandom_range(0, 1));
        2: addr_ready = (k % 3) == 0;
        default: addr_ready = 1'b1;
      endcase
      k++;
      if (addr_valid && addr_ready) begin
        if (q.size() == 0) begin
          check("beat_count", beats + 1, r * w);
        end else begin
          e = q.pop_front();
          check("addr", addr_data, e);
          check("last", addr_last, q.size() == 0);
        end
        beats++;
      end
      pvalid = addr_valid;
      pready = addr_ready;
      pdata  = addr_data;
      plast  = addr_last;
      @(posedge ap_clk);
      #1;
      edges++;
    end
    check("done_seen", ap_done, 1);
    check("ready_pulse", ap_ready, 1);
    check("idle_in_done", ap_idle, 0);
    check("valid_in_done", addr_valid, 0);
    check("beats", beats, r * w);
    if (mode == 0)
      check("latency", edges, exp_edges);
    if (r != 0 && w != 0) begin
      check("din0_hold", mul_din0, r - 1);
      check("din1_hold", mul_din1, w);
    end
    @(posedge ap_clk);
    #1;
    check("idle_after", ap_idle, 1);
    check("done_drop", ap_done, 0);
  endtask

  initial begin
    int r, w, b;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_last", addr_last, 0);
    check("rst_data", addr_data, 0);
    check("rst_din0", mul_din0, 0);
    check("rst_din1", mul_din1, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    walk(3, 4, 0, 0);
    walk(2, 3, 0, 2);
    walk(0, 5, 0, 0);
    walk(4, 0, 0, 0);
    walk(1, 1, 0, 0);
    walk(127, 255, 0, 0);

    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(1, 6);
      w = $urandom_range(1, 12);
      b = BASE_EN ? int'($urandom_range(0, (1 << ADDR_W) - 1)) : 0;
      walk(r, w, b, 1);
    end

    // Reset in the middle of the second row of a 4x8 walk.
    @(negedge ap_clk);
    cfg_rows = 4;
    cfg_width = 8;
    cfg_base = '0;
    ap_start = 1'b1;
    addr_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (12) begin
      @(posedge ap_clk);
      #1;
    end
    check("pre_rst_valid", addr_valid, 1);
    check("pre_rst_data", addr_data, 10);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_idle", ap_idle, 1);
    check("mid_rst_valid", addr_valid, 0);
    check("mid_rst_data", addr_data, 0);
    check("mid_rst_last", addr_last, 0);
    check("mid_rst_din0", mul_din0, 0);
    check("mid_rst_din1", mul_din1, 0);
    @(posedge ap_clk);
    #1;
    check("mid_rst_nodone", ap_done, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    walk(1, 2, 0, 0);

    if (BASE_EN)
      walk(2, 2, 100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
